pulse_sequencer: RTL and testbench
==================================

Name: pulse_sequencer

Overview:
- Row-based note sequencer that drives one pulse channel's note_on, note_trigger, phase_inc and song_clk inputs.
- Fetches one 8-bit row command per row from an external pattern ROM and converts note numbers to phase increments.
- Issues the row strobe on tick boundaries.
- Sits between the global tick/sample timing block and the pulse channel; it is the producer side of the channel's note interface.

Parameters:
- PHASE_BITS, 18, width of phase_inc; must match the channel.
- ADDR_BITS, 6, pattern ROM address width.
- TICKS_PER_ROW, 6, tick_clk pulses per row; range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- play  in  1  run enable; low pauses the sequence.
- tick_clk  in  1  one-clk tick strobe; spacing is at least 16 clk cycles.
- rom_addr  out  ADDR_BITS  pattern ROM address.
- rom_data  in  8  ROM data, valid exactly 1 clk after rom_addr changes.
- song_clk  out  1  row strobe, coincident with tick_clk.
- note_trigger  out  1  retrigger strobe, only ever high with song_clk.
- note_on  out  1  gate to the channel.
- phase_inc  out  PHASE_BITS  oscillator increment.
- underrun  out  1  sticky: a row boundary arrived before the prefetch finished.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: rom_addr=0, note_on=0, phase_inc=0, underrun=0, tick_cnt=0, buffer invalid, FSM=FETCH. song_clk and note_trigger are 0 because they are combinational.
- Row encoding, cmd=rom_data[7:6]:
  - 00 REST: note_on<=0, phase_inc unchanged.
  - 01 NOTE n=rom_data[5:0]: note_on<=1, phase_inc<=new, trigger.
  - 10 HOLD: no change, no trigger.
  - 11 END: loop to address 0 and refetch in the same prefetch. If the END is at address 0 itself, decode it as REST (no infinite loop).
- Note conversion:
  - octave = n/12, semitone = n%12, computed by iterative subtract-12, at most 5 iterations. Notes 60..63 give octave 5.
  - phase_inc = NOTE_TABLE[semitone] >> (5-octave), zero-extended to PHASE_BITS.
- Prefetch FSM:
  - FETCH: drive rom_addr.
  - DECODE: capture rom_data. END goes back to FETCH with addr=0.
  - CONVERT: run the divider; skipped for REST and HOLD.
  - READY: buffer valid, rom_addr pre-incremented with wrap at 2^ADDR_BITS, wait.
  - Worst case FETCH to READY is ≤10 clk.
- Row timing:
  - On every tick_clk with play=1: if tick_cnt==0, song_clk=1 (combinational, same cycle) and tick_cnt<=TICKS_PER_ROW-1; otherwise tick_cnt decrements.
  - note_trigger = song_clk & buffer valid & buffer cmd==NOTE, combinational in the same cycle, so the channel sees trigger and strobe together.
  - At the clock edge ending a song_clk cycle with a valid buffer: note_on and phase_inc load from the buffer, the buffer is invalidated, and the FSM goes to FETCH.
  - song_clk with an invalid buffer: treated as HOLD, underrun<=1 (cleared only by reset), no refetch restart; the current prefetch continues.
- Pause: play=0 forces song_clk=0, note_trigger=0, and note_on<=0 on the next clk. tick_cnt and rom_addr are held; prefetch still completes into the buffer. When play returns, the row resumes at the held tick_cnt.
- tick_clk arriving while the FSM is busy affects only tick_cnt.
- Reset mid-prefetch aborts the prefetch; the next fetch is from address 0.

Decomposition:
- Package seq_pkg holds:
  - CMD_REST/NOTE/HOLD/END encodings and the row field positions.
  - NOTE_TABLE[0..11] = 2858,3028,3208,3398,3600,3815,4041,4282,4536,4806,5092,5395 (octave 5 at 48 kHz, 18-bit phase).
- Sub-module note_to_phase: start/done handshake; holds the iterative divider, the table lookup and the shift. done asserts ≤6 clk after start.

Test Plan:
- Reset, ROM[0]=0x79 (NOTE 57), play=1, first tick -> song_clk=1 and note_trigger=1 that cycle; next clk note_on=1, phase_inc=2403.
- TICKS_PER_ROW=6, ROM[1]=0x80 (HOLD) -> next song_clk exactly 6 ticks later, note_trigger=0, phase_inc stays 2403.
- ROM[2]=0x00 then ROM[3]=0xC0 -> REST gives note_on=0 with phase_inc unchanged; END loops and the next row re-plays ROM[0] with trigger. ROM[0]=0xC0 -> decoded as REST, no hang.
- Notes 0 and 63 -> phase_inc 89 (2858>>5) and 3398.
- tick_clk spaced 4 clk with TICKS_PER_ROW=1 -> underrun=1, row treated as HOLD, underrun remains 1 until rst_n.
- play=0 mid-row for 3 ticks -> no song_clk, note_on=0 next clk, tick_cnt frozen; play=1 -> boundary arrives after the remaining ticks.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the pulse sequencer: row command encodings, row field
// positions, FSM states and the octave-5 note table.
package seq_pkg;

    localparam int CMD_HI  = 7;
    localparam int CMD_LO  = 6;
    localparam int NOTE_HI = 5;
    localparam int NOTE_LO = 0;
    localparam int NOTE_W  = NOTE_HI - NOTE_LO + 1;
    localparam int TABLE_W = 13;

    typedef enum logic [1:0] {
        CMD_REST = 2'b00,
        CMD_NOTE = 2'b01,
        CMD_HOLD = 2'b10,
        CMD_END  = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_CONVERT,
        ST_READY
    } seq_state_t;

    // Octave-5 phase increments at 48 kHz for an 18-bit accumulator.
    function automatic logic [TABLE_W-1:0] note_table(input logic [3:0] semi);
        logic [TABLE_W-1:0] v;
        case (semi)
            4'd0:    v = 13'd2858;
            4'd1:    v = 13'd3028;
            4'd2:    v = 13'd3208;
            4'd3:    v = 13'd3398;
            4'd4:    v = 13'd3600;
            4'd5:    v = 13'd3815;
            4'd6:    v = 13'd4041;
            4'd7:    v = 13'd4282;
            4'd8:    v = 13'd4536;
            4'd9:    v = 13'd4806;
            4'd10:   v = 13'd5092;
            4'd11:   v = 13'd5395;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pulse_sequencer_note_to_phase.sv
// Note number to phase increment: iterative divide by 12, table lookup, then a
// right shift by the distance from octave 5.
module note_to_phase
    import seq_pkg::*;
#(
    parameter int PHASE_BITS = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [NOTE_W-1:0]     note,
    output logic                  done,
    output logic [PHASE_BITS-1:0] phase
);

    // Handshake: start is a one-cycle request that is only issued while idle;
    // done is a one-cycle pulse and phase holds its value until the next start.
    logic              busy;
    logic [NOTE_W-1:0] rem;
    logic [2:0]        oct;
    logic [NOTE_W-1:0] rem_nxt;
    logic [2:0]        oct_nxt;
    logic [PHASE_BITS-1:0] tbl_ext;

    always_comb begin
        rem_nxt = rem;
        oct_nxt = oct;
        if (rem >= NOTE_W'(12)) begin
            rem_nxt = rem - NOTE_W'(12);
            oct_nxt = oct + 3'd1;
        end
    end

    // Finishing on the step whose result drops below 12 keeps notes 60..63 at
    // five subtract cycles.
    assign tbl_ext = PHASE_BITS'(note_table(rem_nxt[3:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            phase <= '0;
            rem   <= '0;
            oct   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem  <= note;
                oct  <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                rem <= rem_nxt;
                oct <= oct_nxt;
                if (rem_nxt < NOTE_W'(12)) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    phase <= tbl_ext >> (3'd5 - oct_nxt);
                end
            end
        end
    end

endmodule

// File: rtl/pulse_sequencer.sv
// Row sequencer for one pulse channel: prefetches a row command from the pattern
// ROM, converts notes to phase increments and applies the row on song_clk.
module pulse_sequencer
    import seq_pkg::*;
#(
    parameter int PHASE_BITS    = 18,
    parameter int ADDR_BITS     = 6,
    parameter int TICKS_PER_ROW = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play,
    input  logic                  tick_clk,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [7:0]            rom_data,
    output logic                  song_clk,
    output logic                  note_trigger,
    output logic                  note_on,
    output logic [PHASE_BITS-1:0] phase_inc,
    output logic                  underrun
);

    localparam logic [7:0] TICK_RELOAD = 8'(TICKS_PER_ROW - 1);

    seq_state_t            state;
    logic [7:0]            tick_cnt;
    logic                  buf_valid;
    cmd_t                  buf_cmd;
    logic [PHASE_BITS-1:0] buf_phase;
    cmd_t                  row_cmd;
    cmd_t                  dec_cmd;
    logic                  row_tick;
    logic                  conv_start;
    logic                  conv_done;
    logic [PHASE_BITS-1:0] conv_phase;

    assign row_cmd      = cmd_t'(rom_data[CMD_HI:CMD_LO]);
    assign row_tick     = tick_clk & play;
    assign song_clk     = row_tick & (tick_cnt == 8'd0);
    assign note_trigger = song_clk & buf_valid & (buf_cmd == CMD_NOTE);
    assign conv_start   = (state == ST_DECODE) && (dec_cmd == CMD_NOTE);

    // An END sitting at address 0 would loop forever; it plays as a rest.
    always_comb begin
        dec_cmd = row_cmd;
        if (row_cmd == CMD_END && rom_addr == '0)
            dec_cmd = CMD_REST;
    end

    note_to_phase #(
        .PHASE_BITS(PHASE_BITS)
    ) u_conv (
        .clk  (clk),
        .rst_n(rst_n),
        .start(conv_start),
        .note (rom_data[NOTE_HI:NOTE_LO]),
        .done (conv_done),
        .phase(conv_phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            rom_addr  <= '0;
            tick_cnt  <= '0;
            buf_valid <= 1'b0;
            buf_cmd   <= CMD_REST;
            buf_phase <= '0;
            note_on   <= 1'b0;
            phase_inc <= '0;
            underrun  <= 1'b0;
        end else begin
            if (row_tick)
                tick_cnt <= (tick_cnt == 8'd0) ? TICK_RELOAD : tick_cnt - 8'd1;
            if (!play)
                note_on <= 1'b0;

            unique case (state)
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    unique case (dec_cmd)
                        CMD_NOTE: begin
                            buf_cmd <= CMD_NOTE;
                            state   <= ST_CONVERT;
                        end
                        CMD_END: begin
                            rom_addr <= '0;
                            state    <= ST_FETCH;
                        end
                        default: begin
                            buf_cmd   <= dec_cmd;
                            buf_valid <= 1'b1;
                            rom_addr  <= rom_addr + ADDR_BITS'(1);
                            state     <= ST_READY;
                        end
                    endcase
                end
                ST_CONVERT: begin
                    if (conv_done) begin
                        buf_phase <= conv_phase;
                        buf_valid <= 1'b1;
                        rom_addr  <= rom_addr + ADDR_BITS'(1);
                        state     <= ST_READY;
                    end
                end
                ST_READY: ;
            endcase

            // buf_valid implies ST_READY, so this never collides with the prefetch.
            if (song_clk) begin
                if (buf_valid) begin
                    if (buf_cmd == CMD_NOTE) begin
                        note_on   <= 1'b1;
                        phase_inc <= buf_phase;
                    end else if (buf_cmd == CMD_REST) begin
                        note_on <= 1'b0;
                    end
                    buf_valid <= 1'b0;
                    state     <= ST_FETCH;
                end else begin
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboarded bench: one sequencer with six ticks per row and one with a single
// tick per row for the underrun case.
module tb_pulse_sequencer;

    localparam int PB = 18;
    localparam int AB = 6;
    localparam int W  = 29;  // {tick[7:0], trig, note_on, underrun, phase[17:0]}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic play = 1'b0, tick_clk = 1'b0;
    logic play1 = 1'b0, tick1 = 1'b0;

    logic [AB-1:0] rom_addr, rom_addr1;
    logic [7:0]    rom_data, rom_data1;
    logic          song_clk, note_trigger, note_on, underrun;
    logic          song_clk1, note_trigger1, note_on1, underrun1;
    logic [PB-1:0] phase_inc, phase_inc1;

    logic [7:0] rom  [64];
    logic [7:0] rom1 [64];

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q1[$];
    int errors = 0;
    int checks = 0;
    int tick_idx = 0;
    int tick_idx1 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        rom_data1 <= rom1[rom_addr1];
    end

    pulse_sequencer #(.PHASE_BITS(PB), .ADDR_BITS(AB), .TICKS_PER_ROW(6)) dut (
        .clk(clk), .rst_n(rst_n), .play(play), .tick_clk(tick_clk),
        .rom_addr(rom_addr), .rom_data(rom_data), .song_clk(song_clk),
        .note_trigger(note_trigger), .note_on(note_on), .phase_inc(phase_inc),
        .underrun(underrun)
    );

    pulse_sequencer #(.PHASE_BITS(PB), .ADDR_BITS(AB), .TICKS_PER_ROW(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .play(play1), .tick_clk(tick1),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .song_clk(song_clk1),
        .note_trigger(note_trigger1), .note_on(note_on1), .phase_inc(phase_inc1),
        .underrun(underrun1)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic exp_row(input int inst, input int tk, input logic trig, input logic on,
                           input logic urun, input int ph);
        logic [W-1:0] v;
        v = {8'(tk), trig, on, urun, 18'(ph)};
        if (inst == 0) exp_q.push_back(v);
        else           exp_q1.push_back(v);
    endtask

    task automatic row_cmp(input int inst, input logic [W-1:0] got);
        logic [W-1:0] want;
        logic         empty;
        empty = (inst == 0) ? (exp_q.size() == 0) : (exp_q1.size() == 0);
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL row%0d unexpected song_clk at tick %0d", inst, got[28:21]);
        end else begin
            if (inst == 0) want = exp_q.pop_front();
            else           want = exp_q1.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL row%0d: got tick=%0d trig=%0b on=%0b urun=%0b phase=%0d, expected tick=%0d trig=%0b on=%0b urun=%0b phase=%0d",
                         inst, got[28:21], got[20], got[19], got[18], got[17:0],
                         want[28:21], want[20], want[19], want[18], want[17:0]);
            end
        end
    endtask

    // Monitor: song_clk marks a row; the applied note state is sampled one clk later.
    logic       pend = 1'b0, pend1 = 1'b0;
    logic [7:0] cap_tick, cap_tick1;
    logic       cap_trig, cap_trig1;

    always @(negedge clk) begin
        if (pend) begin
            row_cmp(0, {cap_tick, cap_trig, note_on, underrun, phase_inc});
            pend = 1'b0;
        end
        if (pend1) begin
            row_cmp(1, {cap_tick1, cap_trig1, note_on1, underrun1, phase_inc1});
            pend1 = 1'b0;
        end
        if (song_clk) begin
            pend = 1'b1; cap_tick = 8'(tick_idx); cap_trig = note_trigger;
        end else if (note_trigger) begin
            checks++; errors++;
            $display("FAIL trig0: note_trigger=1 without song_clk");
        end
        if (song_clk1) begin
            pend1 = 1'b1; cap_tick1 = 8'(tick_idx1); cap_trig1 = note_trigger1;
        end else if (note_trigger1) begin
            checks++; errors++;
            $display("FAIL trig1: note_trigger=1 without song_clk");
        end
    end

    // ---------------- drivers ----------------
    task automatic clear_roms();
        foreach (rom[i])  rom[i]  = 8'h00;
        foreach (rom1[i]) rom1[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; play = 1'b0; play1 = 1'b0; tick_clk = 1'b0; tick1 = 1'b0;
        tick_idx = 0; tick_idx1 = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One tick pulse, then idle so the next pulse starts 'gap' clocks later.
    task automatic tick(input int inst, input int gap);
        @(posedge clk); #1;
        if (inst == 0) begin tick_idx++;  tick_clk = 1'b1; end
        else           begin tick_idx1++; tick1 = 1'b1;    end
        @(posedge clk); #1;
        tick_clk = 1'b0; tick1 = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset values and basic row types: NOTE 57, HOLD, REST, END loop.
        clear_roms();
        rom[0] = 8'h79; rom[1] = 8'h80; rom[2] = 8'h00; rom[3] = 8'hC0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_note_on", 32'(note_on), 0);
        check("rst_phase_inc", 32'(phase_inc), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_song_clk", 32'(song_clk), 0);
        check("rst_note_trigger", 32'(note_trigger), 0);
        do_reset();
        repeat (12) @(posedge clk);
        play = 1'b1;
        exp_row(0, 1,  1'b1, 1'b1, 1'b0, 2403);
        exp_row(0, 7,  1'b0, 1'b1, 1'b0, 2403);
        exp_row(0, 13, 1'b0, 1'b0, 1'b0, 2403);
        exp_row(0, 19, 1'b1, 1'b1, 1'b0, 2403);
        exp_row(0, 25, 1'b0, 1'b1, 1'b0, 2403);
        for (int i = 0; i < 25; i++) tick(0, 16);
        repeat (12) @(posedge clk);
        check("s1_rom_addr", 32'(rom_addr), 3);
        check("s1_drained", 32'(exp_q.size()), 0);

        // END at address 0 plays as REST; note 0 and note 63 extremes.
        clear_roms();
        rom[0] = 8'hC0; rom[1] = 8'h40; rom[2] = 8'h7F;
        do_reset();
        repeat (12) @(posedge clk);
        play = 1'b1;
        exp_row(0, 1,  1'b0, 1'b0, 1'b0, 0);
        exp_row(0, 7,  1'b1, 1'b1, 1'b0, 89);
        exp_row(0, 13, 1'b1, 1'b1, 1'b0, 3398);
        for (int i = 0; i < 13; i++) tick(0, 16);
        repeat (10) @(posedge clk);
        check("s2_drained", 32'(exp_q.size()), 0);

        // Pause for three ticks mid-row: the boundary moves from tick 7 to tick 10.
        clear_roms();
        rom[0] = 8'h79; rom[1] = 8'h80; rom[2] = 8'h80;
        do_reset();
        repeat (12) @(posedge clk);
        play = 1'b1;
        exp_row(0, 1,  1'b1, 1'b1, 1'b0, 2403);
        exp_row(0, 10, 1'b0, 1'b0, 1'b0, 2403);
        for (int i = 0; i < 3; i++) tick(0, 16);
        @(posedge clk); #1 play = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pause_note_on", 32'(note_on), 0);
        for (int i = 0; i < 3; i++) tick(0, 16);
        check("pause_rom_addr", 32'(rom_addr), 2);
        check("pause_phase_inc", 32'(phase_inc), 2403);
        @(posedge clk); #1 play = 1'b1;
        for (int i = 0; i < 4; i++) tick(0, 16);
        repeat (10) @(posedge clk);
        check("s3_drained", 32'(exp_q.size()), 0);

        // One tick per row at 4-clk spacing outruns the prefetch of note 63.
        clear_roms();
        rom1[0] = 8'h40; rom1[1] = 8'h7F; rom1[2] = 8'h40;
        do_reset();
        repeat (12) @(posedge clk);
        play1 = 1'b1;
        exp_row(1, 1, 1'b1, 1'b1, 1'b0, 89);
        exp_row(1, 2, 1'b0, 1'b1, 1'b1, 89);
        exp_row(1, 3, 1'b1, 1'b1, 1'b1, 3398);
        tick(1, 4);
        tick(1, 4);
        repeat (20) @(posedge clk);
        tick(1, 16);
        repeat (10) @(posedge clk);
        check("urun_sticky", 32'(underrun1), 1);
        check("s4_drained", 32'(exp_q1.size()), 0);
        rst_n = 1'b0;
        #1;
        check("urun_cleared", 32'(underrun1), 0);
        check("urun_rst_note_on", 32'(note_on1), 0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
